// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_types_pkg
//  Description : Shared CPU datapath types used by the instruction cache.
//                word_t - one 32-bit machine word.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage
`default_nettype wire

// File: rtl/icache_assoc_if.sv
`default_nettype none
// ============================================================================
//  Interface   : icache_assoc_if
//  Description : Fetch-side and memory-side signals of the instruction cache.
//                slave  - the cache: takes fetch requests, issues memory reads
//                master - the environment: datapath fetch port + memory
//                Fetch : imemREN, imemaddr, iflush -> ihit, imemload
//                Memory: iwait, iload              -> iREN, iaddr
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_assoc_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iflush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// ============================================================================
//  Module      : icache_way
//  Description : One way of the set-associative instruction cache.
//                Valid bits, tags and block data per set; combinational read
//                by index, whole-line write, global valid clear.
//                CLK, RST        - clock, synchronous active-high reset
//                clr_all         - invalidate every set (wins over a write)
//                rd_idx          - lookup index -> rd_valid, rd_tag, rd_data
//                wr_en/wr_idx    - write wr_tag/wr_data as a valid line
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_way
    import cpu_types_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2,
    parameter int IDX         = 3,
    parameter int TAGW        = 26
) (
    input  wire logic                          CLK,
    input  wire logic                          RST,
    input  wire logic                          clr_all,
    input  wire logic [IDX-1:0]                rd_idx,
    output      logic                          rd_valid,
    output      logic [TAGW-1:0]               rd_tag,
    output      word_t [BLOCK_WORDS-1:0]       rd_data,
    input  wire logic                          wr_en,
    input  wire logic [IDX-1:0]                wr_idx,
    input  wire logic [TAGW-1:0]               wr_tag,
    input  wire word_t [BLOCK_WORDS-1:0]       wr_data
);
    logic [SETS-1:0]         valid_q, valid_d;
    logic [TAGW-1:0]         tag_mem  [SETS];
    word_t [BLOCK_WORDS-1:0] data_mem [SETS];

    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data storage needs no reset: a line is only visible once valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];
endmodule
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : icache_assoc
//  Description : Set-associative instruction cache with burst refill, LRU
//                replacement, flush and hit/miss counters.
//                CLK, RST             - clock, synchronous active-high reset
//                bus (slave)          - fetch port and memory read port
//                hit_count/miss_count - wrapping event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_assoc
    import cpu_types_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    icache_assoc_if.slave bus,
    output      word_t    hit_count,
    output      word_t    miss_count
);
    localparam int    WOFF     = $clog2(BLOCK_WORDS);
    localparam int    IDX      = $clog2(SETS);
    localparam int    TAGW     = 30 - WOFF - IDX;
    localparam int    KW       = (WOFF > 0) ? WOFF : 1;
    localparam word_t OFF_MASK = word_t'(BLOCK_WORDS * 4 - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    word_t                   base_q, base_d;
    logic                    victim_q, victim_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    flush_pend_q, flush_pend_d;
    word_t [BLOCK_WORDS-1:0] stage_q, stage_d;
    logic [SETS-1:0]         lru_q, lru_d;
    word_t                   hit_count_q, hit_count_d;
    word_t                   miss_count_q, miss_count_d;

    logic [TAGW-1:0] req_tag, fill_tag;
    logic [IDX-1:0]  req_idx, fill_idx;
    logic [KW-1:0]   req_woff;
    logic            unused_addr_lsbs;

    assign req_tag          = bus.imemaddr[31 -: TAGW];
    assign req_idx          = bus.imemaddr[2 + WOFF +: IDX];
    assign req_woff         = (WOFF > 0) ? bus.imemaddr[2 +: KW] : '0;
    assign fill_tag         = base_q[31 -: TAGW];
    assign fill_idx         = base_q[2 + WOFF +: IDX];
    assign unused_addr_lsbs = ^bus.imemaddr[1:0];

    logic [WAYS-1:0]         way_valid, way_match, way_wr;
    logic [TAGW-1:0]         way_tag  [WAYS];
    word_t [BLOCK_WORDS-1:0] way_data [WAYS];
    word_t [BLOCK_WORDS-1:0] line_data;
    logic                    clr_all, fill_commit, lookup_hit, any_match;
    logic                    hit_way, victim_sel;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS), .IDX(IDX), .TAGW(TAGW)
        ) u_way (
            .CLK(CLK), .RST(RST), .clr_all(clr_all),
            .rd_idx(req_idx), .rd_valid(way_valid[w]),
            .rd_tag(way_tag[w]), .rd_data(way_data[w]),
            .wr_en(way_wr[w]), .wr_idx(fill_idx),
            .wr_tag(fill_tag), .wr_data(line_data)
        );
        assign way_match[w] = way_valid[w] && (way_tag[w] == req_tag);
        assign way_wr[w]    = fill_commit && (int'(victim_q) == w);
    end

    assign any_match = |way_match;

    always_comb begin
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) hit_way = 1'(w);
        end
    end

    // Lowest invalid way first; LRU way only when the whole set is valid.
    always_comb begin
        victim_sel = 1'b0;
        if (WAYS == 2) begin
            if (!way_valid[0])             victim_sel = 1'b0;
            else if (!way_valid[WAYS-1])   victim_sel = 1'b1;
            else                           victim_sel = lru_q[req_idx];
        end
    end

    // The last word goes straight from iload into the line being written.
    always_comb begin
        line_data       = stage_q;
        line_data[k_q]  = bus.iload;
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        victim_d     = victim_q;
        k_d          = k_q;
        flush_pend_d = flush_pend_q;
        stage_d      = stage_q;
        lru_d        = lru_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        clr_all      = 1'b0;
        fill_commit  = 1'b0;
        lookup_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iflush) begin
                    clr_all = 1'b1;
                    lru_d   = '0;
                end else if (bus.imemREN) begin
                    if (any_match) begin
                        lookup_hit  = 1'b1;
                        hit_count_d = hit_count_q + 32'd1;
                        if (WAYS == 2) lru_d[req_idx] = ~hit_way;
                    end else begin
                        base_d       = {bus.imemaddr[31:2], 2'b00} & ~OFF_MASK;
                        victim_d     = victim_sel;
                        k_d          = '0;
                        miss_count_d = miss_count_q + 32'd1;
                        state_d      = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.iflush) flush_pend_d = 1'b1;
                if (!bus.iwait) begin
                    stage_d[k_q] = bus.iload;
                    if (k_q == KW'(BLOCK_WORDS - 1)) begin
                        state_d      = IDLE;
                        flush_pend_d = 1'b0;
                        // A flush seen at any point of the fill discards the line.
                        if (flush_pend_q || bus.iflush) begin
                            clr_all = 1'b1;
                            lru_d   = '0;
                        end else begin
                            fill_commit = 1'b1;
                            if (WAYS == 2) lru_d[fill_idx] = ~victim_q;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            base_q       <= '0;
            victim_q     <= 1'b0;
            k_q          <= '0;
            flush_pend_q <= 1'b0;
            stage_q      <= '0;
            lru_q        <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            victim_q     <= victim_d;
            k_q          <= k_d;
            flush_pend_q <= flush_pend_d;
            stage_q      <= stage_d;
            lru_q        <= lru_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.ihit     = !RST && lookup_hit;
    assign bus.imemload = bus.ihit ? way_data[hit_way][req_woff] : '0;
    assign bus.iREN     = !RST && (state_q == FILL);
    assign bus.iaddr    = bus.iREN ? (base_q + (word_t'(k_q) << 2)) : '0;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;
endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_assoc
//  Description : Directed self-checking bench for icache_assoc. Memory
//                returns data equal to the requested address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    word_t hc, mc, hc1, mc1;
    int    passed = 0;
    int    failed = 0;
    int    total  = 0;

    always #5 CLK = ~CLK;

    icache_assoc_if bus ();
    icache_assoc_if bus1 ();

    assign bus.iload  = bus.iaddr;
    assign bus1.iload = bus1.iaddr;

    icache_assoc #(.SETS(8), .WAYS(2), .BLOCK_WORDS(2)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .hit_count(hc), .miss_count(mc)
    );

    icache_assoc #(.SETS(16), .WAYS(1), .BLOCK_WORDS(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1), .hit_count(hc1), .miss_count(mc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full miss on the default instance: detect, two fill beats, then hit.
    task automatic miss0(input word_t a);
        word_t base;
        base = a & ~32'h7;
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        #1;
        chk("miss_detect_ihit", 32'(bus.ihit), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("fill_iREN", 32'(bus.iREN), 32'd1);
            chk("fill_iaddr", bus.iaddr, base + 32'(4 * k));
            tick();
        end
        chk("refill_ihit", 32'(bus.ihit), 32'd1);
        chk("refill_data", bus.imemload, a);
        bus.imemREN = 1'b0;
    endtask

    task automatic hit0(input word_t a);
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        #1;
        chk("hit_ihit", 32'(bus.ihit), 32'd1);
        chk("hit_data", bus.imemload, a);
        tick();
        bus.imemREN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        bus.imemREN = 1'b0;  bus.imemaddr = '0;  bus.iflush = 1'b0;  bus.iwait = 1'b0;
        bus1.imemREN = 1'b0; bus1.imemaddr = '0; bus1.iflush = 1'b0; bus1.iwait = 1'b0;
        tick();
        tick();
        chk("rst_ihit", 32'(bus.ihit), 32'd0);
        chk("rst_iREN", 32'(bus.iREN), 32'd0);

        RST = 1'b0;
        #1;
        chk("post_rst_ihit", 32'(bus.ihit), 32'd0);
        chk("post_rst_iREN", 32'(bus.iREN), 32'd0);
        chk("post_rst_iaddr", bus.iaddr, 32'd0);
        chk("post_rst_imemload", bus.imemload, 32'd0);
        chk("post_rst_hits", hc, 32'd0);
        chk("post_rst_misses", mc, 32'd0);

        // Basic fill and same-block hits.
        miss0(32'h40);
        hit0(32'h40);
        hit0(32'h44);
        chk("basic_hits", hc, 32'd2);
        chk("basic_misses", mc, 32'd1);

        // Set-0 conflict: 0x80 is LRU when 0xC0 arrives.
        miss0(32'h80);
        hit0(32'h40);
        miss0(32'hC0);
        hit0(32'h40);
        miss0(32'h80);
        chk("conflict_hits", hc, 32'd4);
        chk("conflict_misses", mc, 32'd4);

        // Slow memory: three wait cycles per word.
        bus.iwait = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h100;
        #1;
        chk("wait_detect_ihit", 32'(bus.ihit), 32'd0);
        tick();
        for (int w = 0; w < 3; w++) begin
            chk("wait0_iREN", 32'(bus.iREN), 32'd1);
            chk("wait0_iaddr", bus.iaddr, 32'h100);
            chk("wait0_ihit", 32'(bus.ihit), 32'd0);
            tick();
        end
        bus.iwait = 1'b0;
        #1;
        chk("accept0_iaddr", bus.iaddr, 32'h100);
        tick();
        bus.iwait = 1'b1;
        for (int w = 0; w < 3; w++) begin
            chk("wait1_iREN", 32'(bus.iREN), 32'd1);
            chk("wait1_iaddr", bus.iaddr, 32'h104);
            chk("wait1_ihit", 32'(bus.ihit), 32'd0);
            tick();
        end
        bus.iwait = 1'b0;
        #1;
        chk("accept1_iaddr", bus.iaddr, 32'h104);
        tick();
        chk("wait_done_ihit", 32'(bus.ihit), 32'd1);
        chk("wait_done_data", bus.imemload, 32'h100);
        bus.imemREN = 1'b0;

        // Flush in IDLE beats a simultaneous hit.
        miss0(32'h40);
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iflush = 1'b1;
        #1;
        chk("flush_idle_ihit", 32'(bus.ihit), 32'd0);
        tick();
        bus.iflush = 1'b0; bus.imemREN = 1'b0;
        chk("flush_idle_hits", hc, 32'd4);
        chk("flush_idle_misses", mc, 32'd6);
        miss0(32'h40);

        // Flush during a fill discards that line and everything else.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h200;
        #1;
        chk("flush_fill_detect", 32'(bus.ihit), 32'd0);
        tick();
        bus.iflush = 1'b1;
        tick();
        bus.iflush = 1'b0;
        #1;
        chk("flush_fill_iREN", 32'(bus.iREN), 32'd1);
        chk("flush_fill_iaddr", bus.iaddr, 32'h204);
        tick();
        chk("flush_fill_done_iREN", 32'(bus.iREN), 32'd0);
        miss0(32'h200);
        miss0(32'h40);
        chk("flush_fill_hits", hc, 32'd4);
        chk("flush_fill_misses", mc, 32'd10);

        // Reset in the middle of a fill.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h80;
        #1;
        chk("rstfill_detect", 32'(bus.ihit), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        #1;
        chk("rstfill_ihit_in_rst", 32'(bus.ihit), 32'd0);
        tick();
        chk("rstfill_iREN", 32'(bus.iREN), 32'd0);
        chk("rstfill_hits", hc, 32'd0);
        chk("rstfill_misses", mc, 32'd0);
        bus.imemREN = 1'b0;
        RST = 1'b0;
        #1;
        miss0(32'h40);
        chk("after_rst_misses", mc, 32'd1);

        // Direct-mapped, single-word instance: 0x0 and 0x40 share set 0.
        for (int i = 0; i < 4; i++) begin
            word_t a;
            a = (i % 2 == 1) ? 32'h40 : 32'h0;
            bus1.imemREN  = 1'b1;
            bus1.imemaddr = a;
            #1;
            chk("dm_detect_ihit", 32'(bus1.ihit), 32'd0);
            tick();
            chk("dm_fill_iREN", 32'(bus1.iREN), 32'd1);
            chk("dm_fill_iaddr", bus1.iaddr, a);
            tick();
            chk("dm_refill_ihit", 32'(bus1.ihit), 32'd1);
            chk("dm_refill_data", bus1.imemload, a);
            chk("dm_misses", mc1, 32'(i + 1));
            bus1.imemREN = 1'b0;
        end
        chk("dm_hits", hc1, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
